arb_slave_model: RTL

ARB_SLAVE_MODEL -- requirements
Module: arb_slave_model

---
 rtl/arb_slave_model.sv | 135 +++++++++++++
 1 files changed

// File: rtl/arb_slave_model.sv
// Bus slave model for arbitrator tests: per-slot expected-write and read-value registers,
// optional wait states, ack/err strobes and saturating error/write/read counters.
module arb_slave_model #(
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IDX_LSB = 4,
  parameter logic [31:0] BASE    = 32'hFFEF_0200,
  parameter logic [31:0] MASK    = 32'hFFEF_FF00,
  parameter int unsigned WAIT    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    id,
  input  logic          sel,
  input  logic [31:0]   addr,
  input  logic          rw,
  input  logic [DW-1:0] data_to_slave,
  output logic [DW-1:0] data_from_slave,
  output logic          ack,
  output logic          err,
  output logic [15:0]   err_cnt,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            abort_q, abort_d;
  logic            latch, commit, mismatch, addr_good;
  logic [IW-1:0]   cur_idx, idx_q;
  logic            bad_q, rw_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   wexp_q [DEPTH];
  logic [DW-1:0]   rval_q [DEPTH];
  logic [15:0]     err_cnt_q, wr_cnt_q, rd_cnt_q;
  logic [DW-1:0]   rst_wexp, rst_rval;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cur_idx   = addr[IDX_LSB +: IW];
  assign addr_good = (addr & MASK) == (BASE | {16'h0, id, 12'h0});
  assign rst_wexp  = {id, {(DW-4){1'b0}}};
  assign rst_rval  = {{(DW-4){1'b0}}, id} << (DW-8);

  assign data_from_slave = rval_q[cur_idx];
  assign err_cnt         = err_cnt_q;
  assign wr_cnt          = wr_cnt_q;
  assign rd_cnt          = rd_cnt_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    abort_d = 1'b0;
    latch   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel) begin
          latch = 1'b1;
          if (WAIT > 0) begin
            state_d = StWait;
            wcnt_d  = 4'(WAIT - 1);
          end else begin
            state_d = StAck;
          end
        end
      end
      StWait: begin
        // Losing sel mid-wait aborts; the err strobe follows one cycle later from IDLE.
        if (!sel) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end else if (wcnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
        commit  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mismatch = rw_q && (data_q != wexp_q[idx_q]);
    ack      = (state_q == StAck);
    err      = (ack && (bad_q || mismatch)) || abort_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      wcnt_q    <= 4'd0;
      abort_q   <= 1'b0;
      idx_q     <= '0;
      bad_q     <= 1'b0;
      rw_q      <= 1'b0;
      data_q    <= '0;
      err_cnt_q <= 16'd0;
      wr_cnt_q  <= 16'd0;
      rd_cnt_q  <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        wexp_q[i] <= rst_wexp;
        rval_q[i] <= rst_rval;
      end
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      abort_q   <= abort_d;
      if (latch) begin
        idx_q  <= cur_idx;
        bad_q  <= !addr_good;
        rw_q   <= rw;
        data_q <= data_to_slave;
      end
      err_cnt_q <= err ? sat_inc(err_cnt_q) : err_cnt_q;
      wr_cnt_q  <= (commit && !bad_q && rw_q) ? sat_inc(wr_cnt_q) : wr_cnt_q;
      rd_cnt_q  <= (commit && !bad_q && !rw_q) ? sat_inc(rd_cnt_q) : rd_cnt_q;
      if (commit && !bad_q) begin
        if (rw_q) wexp_q[idx_q] <= wexp_q[idx_q] + DW'(1);
        else      rval_q[idx_q] <= rval_q[idx_q] + DW'(1);
      end
    end
  end

endmodule
